// File: rtl/hq_blend_diff_if.sv
// Pixel-blend request/result bundle: sample inputs toward the blender, registered results back.
// master drives samples and receives results; slave is the blender side.
interface hq_blend_diff_if;
  logic        in_valid;
  logic [5:0]  rule;
  logic        disable_hq2x;
  logic [14:0] e;
  logic [14:0] a;
  logic [14:0] b;
  logic [14:0] d;
  logic [14:0] f;
  logic [14:0] h;
  logic [14:0] cmp_x;
  logic [14:0] cmp_y;
  logic        out_valid;
  logic [14:0] blend_out;
  logic        diff_out;

  modport master (
    output in_valid, rule, disable_hq2x, e, a, b, d, f, h, cmp_x, cmp_y,
    input  out_valid, blend_out, diff_out
  );

  modport slave (
    input  in_valid, rule, disable_hq2x, e, a, b, d, f, h, cmp_x, cmp_y,
    output out_valid, blend_out, diff_out
  );
endinterface

// File: rtl/hq_blend_diff.sv
// hq2x pixel blender with YUV-style similarity check; fixed 1-cycle latency.
// No backpressure: results register every cycle and out_valid only qualifies them.
module hq_blend_diff (
  input  logic           clk,
  input  logic           rst_n,
  hq_blend_diff_if.slave bus
);

  typedef enum logic [2:0] {
    M0, M1, M2, M3, M4, M5, M6
  } mode_e;

  // 1 when the two RGB555 pixels are perceptibly different.
  function automatic logic pix_diff(input logic [14:0] p, input logic [14:0] q);
    logic signed [8:0] dr;
    logic signed [8:0] dg;
    logic signed [8:0] db;
    logic signed [8:0] t;
    logic signed [8:0] y;
    logic signed [8:0] u;
    logic signed [8:0] v;
    dr = $signed({4'b0, p[4:0]})   - $signed({4'b0, q[4:0]});
    dg = $signed({4'b0, p[9:5]})   - $signed({4'b0, q[9:5]});
    db = $signed({4'b0, p[14:10]}) - $signed({4'b0, q[14:10]});
    t  = dr + db;
    y  = t + dg;
    u  = dr - db;
    v  = (dg <<< 1) - t;
    pix_diff = !((y >= -9'sd24) && (y <= 9'sd23) &&
                 (u >= -9'sd4)  && (u <= 9'sd3)  &&
                 (v >= -9'sd6)  && (v <= 9'sd5));
  endfunction

  // Weights always sum to 16, so the 9-bit sum cannot overflow and >>4 yields 5 bits.
  function automatic logic [4:0] mix_chan(
    input logic [4:0] ec, input logic [4:0] xc, input logic [4:0] yc,
    input logic [4:0] we, input logic [4:0] wx, input logic [4:0] wy
  );
    logic [8:0] sum;
    sum = 9'(ec) * 9'(we) + 9'(xc) * 9'(wx) + 9'(yc) * 9'(wy);
    mix_chan = sum[8:4];
  endfunction

  logic [14:0] blend_q;
  logic [14:0] blend_d;
  logic        diff_q;
  logic        diff_d;
  logic        out_valid_q;
  logic        out_valid_d;

  logic [3:0]  code;
  logic [14:0] cmp_p;
  logic [14:0] cmp_q;
  logic        similar;
  mode_e       mode;
  logic [14:0] x_pix;
  logic [14:0] y_pix;
  logic [4:0]  w_e;
  logic [4:0]  w_x;
  logic [4:0]  w_y;

  always_comb begin
    code    = bus.rule[5:2];
    cmp_p   = bus.rule[1] ? bus.b : bus.h;
    cmp_q   = bus.rule[0] ? bus.d : bus.f;
    similar = !pix_diff(cmp_p, cmp_q);
    mode    = M0;
    x_pix   = bus.d;
    y_pix   = bus.b;

    if (bus.disable_hq2x) begin
      mode = M0;
    end else if (!code[3]) begin
      // Low codes blend unconditionally; similarity is ignored.
      case (code[2:0])
        3'd1:    begin mode = M1; x_pix = bus.a; end
        3'd2:    begin mode = M1; x_pix = bus.d; end
        3'd3:    begin mode = M1; x_pix = bus.b; end
        3'd4:    begin mode = M2; x_pix = bus.d; y_pix = bus.b; end
        3'd5:    begin mode = M2; x_pix = bus.a; y_pix = bus.b; end
        3'd6:    begin mode = M2; x_pix = bus.a; y_pix = bus.d; end
        default: mode = M0;
      endcase
    end else if (!similar) begin
      case (code[2:0])
        3'd3, 3'd4, 3'd5: begin mode = M1; x_pix = bus.a; end
        3'd6:             begin mode = M1; x_pix = bus.d; end
        3'd7:             begin mode = M1; x_pix = bus.b; end
        default:          mode = M0;
      endcase
    end else begin
      case (code[2:0])
        3'd0, 3'd3: mode = M2;
        3'd1, 3'd5: mode = M5;
        3'd2:       mode = M6;
        3'd4:       mode = M4;
        3'd6:       begin mode = M3; x_pix = bus.b; y_pix = bus.d; end
        default:    mode = M3;
      endcase
    end

    case (mode)
      M1:      begin w_e = 5'd12; w_x = 5'd4; w_y = 5'd0; end
      M2:      begin w_e = 5'd8;  w_x = 5'd4; w_y = 5'd4; end
      M3:      begin w_e = 5'd10; w_x = 5'd4; w_y = 5'd2; end
      M4:      begin w_e = 5'd12; w_x = 5'd2; w_y = 5'd2; end
      M5:      begin w_e = 5'd4;  w_x = 5'd6; w_y = 5'd6; end
      M6:      begin w_e = 5'd14; w_x = 5'd1; w_y = 5'd1; end
      default: begin w_e = 5'd16; w_x = 5'd0; w_y = 5'd0; end
    endcase

    blend_d[4:0]   = mix_chan(bus.e[4:0],   x_pix[4:0],   y_pix[4:0],   w_e, w_x, w_y);
    blend_d[9:5]   = mix_chan(bus.e[9:5],   x_pix[9:5],   y_pix[9:5],   w_e, w_x, w_y);
    blend_d[14:10] = mix_chan(bus.e[14:10], x_pix[14:10], y_pix[14:10], w_e, w_x, w_y);
    diff_d         = pix_diff(bus.cmp_x, bus.cmp_y);
    out_valid_d    = bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blend_q     <= 15'h0000;
      diff_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      blend_q     <= blend_d;
      diff_q      <= diff_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.blend_out = blend_q;
  assign bus.diff_out  = diff_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_hq_blend_diff.sv
// Bench for hq_blend_diff: directed vector table, random stream against a reference model,
// and hand-written reset/pulse sequences.
module tb_hq_blend_diff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hq_blend_diff_if bus ();

  hq_blend_diff dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0]  rule;
    logic        dis;
    logic [14:0] e, a, b, d, f, h, cx, cy;
    logic [14:0] exp_blend;
    logic        exp_diff;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic [5:0] rule, input logic dis,
                              input logic [14:0] e, a, b, d, f, h, cx, cy,
                              input logic [14:0] exp_blend, input logic exp_diff);
    vec_t v;
    v.rule = rule; v.dis = dis; v.e = e; v.a = a; v.b = b; v.d = d; v.f = f; v.h = h;
    v.cx = cx; v.cy = cy; v.exp_blend = exp_blend; v.exp_diff = exp_diff;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: straight from the per-channel arithmetic and the rule tables.
  function automatic int ch(input int p, input int k);
    return (p >> (5 * k)) & 31;
  endfunction

  function automatic int m_diff(input int p, input int q);
    int dr, dg, db, y, u, v;
    dr = ch(p, 0) - ch(q, 0);
    dg = ch(p, 1) - ch(q, 1);
    db = ch(p, 2) - ch(q, 2);
    y = dr + db + dg;
    u = dr - db;
    v = 2 * dg - (dr + db);
    return (y >= -24 && y <= 23 && u >= -4 && u <= 3 && v >= -6 && v <= 5) ? 0 : 1;
  endfunction

  function automatic int m_blend(input int rule, input int dis,
                                 input int e, a, b, d, f, h);
    int c, s, mode, x, y, res, ec, xc, yc, o;
    c = rule >> 2;
    s = 1 - m_diff(((rule & 2) != 0) ? b : h, ((rule & 1) != 0) ? d : f);
    mode = 0; x = 0; y = 0;
    if (dis != 0) mode = 0;
    else if (c < 8) begin
      case (c)
        1: begin mode = 1; x = a; end
        2: begin mode = 1; x = d; end
        3: begin mode = 1; x = b; end
        4: begin mode = 2; x = d; y = b; end
        5: begin mode = 2; x = a; y = b; end
        6: begin mode = 2; x = a; y = d; end
        default: mode = 0;
      endcase
    end else if (s == 0) begin
      if (c >= 11 && c <= 13) begin mode = 1; x = a; end
      else if (c == 14) begin mode = 1; x = d; end
      else if (c == 15) begin mode = 1; x = b; end
    end else begin
      x = d; y = b;
      case (c)
        8, 11: mode = 2;
        9, 13: mode = 5;
        10: mode = 6;
        12: mode = 4;
        14: begin mode = 3; x = b; y = d; end
        default: mode = 3;
      endcase
    end
    res = 0;
    for (int k = 0; k < 3; k++) begin
      ec = ch(e, k); xc = ch(x, k); yc = ch(y, k);
      case (mode)
        1: o = (12 * ec + 4 * xc) / 16;
        2: o = (8 * ec + 4 * xc + 4 * yc) / 16;
        3: o = (10 * ec + 4 * xc + 2 * yc) / 16;
        4: o = (12 * ec + 2 * xc + 2 * yc) / 16;
        5: o = (4 * ec + 6 * xc + 6 * yc) / 16;
        6: o = (14 * ec + xc + yc) / 16;
        default: o = ec;
      endcase
      res = res | (o << (5 * k));
    end
    return res;
  endfunction

  task automatic drive(input logic vld, input vec_t v);
    bus.in_valid = vld; bus.rule = v.rule; bus.disable_hq2x = v.dis;
    bus.e = v.e; bus.a = v.a; bus.b = v.b; bus.d = v.d; bus.f = v.f; bus.h = v.h;
    bus.cmp_x = v.cx; bus.cmp_y = v.cy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t rv;
  int   base;

  initial begin
    tbl[0]  = mk(6'h00, 0, 15'h1234, 0, 0, 0, 0, 0, 15'h0000, 15'h0004, 15'h1234, 0);
    tbl[1]  = mk(6'h00, 0, 15'h1234, 0, 0, 0, 0, 0, 15'h0000, 15'h0005, 15'h1234, 1);
    tbl[2]  = mk(6'h04, 0, 15'h001F, 0, 0, 0, 0, 0, 0, 0, 15'h0017, 0);
    tbl[3]  = mk(6'h04, 1, 15'h001F, 0, 0, 0, 0, 0, 0, 0, 15'h001F, 0);
    tbl[4]  = mk(6'h27, 0, 15'h0000, 0, 15'h7FFF, 15'h7FFF, 0, 0, 0, 0, 15'h5EF7, 0);
    tbl[5]  = mk(6'h27, 0, 15'h0000, 0, 15'h7FFF, 15'h0000, 0, 0, 0, 0, 15'h0000, 0);
    tbl[6]  = mk(6'h2B, 0, 15'h0000, 0, 15'h7FFF, 15'h7FFF, 0, 0, 0, 0, 15'h0C63, 0);
    tbl[7]  = mk(6'h27, 1, 15'h1111, 0, 15'h7FFF, 15'h7FFF, 0, 0, 0, 0, 15'h1111, 0);
    tbl[8]  = mk(6'h3B, 0, 15'h0000, 0, 15'h001F, 15'h001F, 0, 0, 0, 0, 15'h000B, 0);
    tbl[9]  = mk(6'h3B, 0, 15'h001F, 0, 15'h001F, 15'h0000, 0, 0, 0, 0, 15'h0017, 0);
    tbl[10] = mk(6'h33, 0, 15'h0000, 0, 15'h03E0, 15'h03E0, 0, 0, 0, 0, 15'h00E0, 0);
    tbl[11] = mk(6'h00, 0, 15'h0000, 0, 0, 0, 0, 0, 15'h0003, 15'h0000, 15'h0000, 0);
    tbl[12] = mk(6'h00, 0, 15'h0000, 0, 0, 0, 0, 0, 15'h0004, 15'h0000, 15'h0000, 1);
    tbl[13] = mk(6'h00, 0, 15'h0000, 0, 0, 0, 0, 0, 15'h0000, 15'h2108, 15'h0000, 0);
    tbl[14] = mk(6'h00, 0, 15'h0000, 0, 0, 0, 0, 0, 15'h2108, 15'h0000, 15'h0000, 1);
    tbl[15] = mk(6'h00, 0, 15'h0000, 0, 0, 0, 0, 0, 15'h2107, 15'h0000, 15'h0000, 0);
    tbl[16] = mk(6'h00, 0, 15'h0000, 0, 0, 0, 0, 0, 15'h0060, 15'h0000, 15'h0000, 1);

    // Reset held with in_valid asserted and a vector that would otherwise produce nonzero outputs.
    rst_n = 1'b0;
    drive(1'b1, mk(6'h04, 0, 15'h001F, 0, 0, 0, 0, 0, 15'h7FFF, 15'h0000, 0, 0));
    tick();
    tick();
    check("reset_out_valid", {15'h0, bus.out_valid}, 16'h0);
    check("reset_blend", {1'b0, bus.blend_out}, 16'h0);
    check("reset_diff", {15'h0, bus.diff_out}, 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(1'b1, tbl[i]);
      tick();
      check($sformatf("tbl%0d_blend", i), {1'b0, bus.blend_out}, {1'b0, tbl[i].exp_blend});
      check($sformatf("tbl%0d_diff", i), {15'h0, bus.diff_out}, {15'h0, tbl[i].exp_diff});
      check($sformatf("tbl%0d_valid", i), {15'h0, bus.out_valid}, 16'h1);
    end

    for (int i = 0; i < 400; i++) begin
      rv.rule = 6'($urandom_range(0, 63));
      rv.dis  = ($urandom_range(0, 7) == 0);
      rv.e    = 15'($urandom_range(0, 32767));
      rv.a    = 15'($urandom_range(0, 32767));
      if ($urandom_range(0, 1) == 1) begin
        base = $urandom_range(0, 32767);
        rv.b = 15'(base);
        rv.d = 15'(base ^ $urandom_range(0, 3));
        rv.f = 15'(base ^ ($urandom_range(0, 3) << 5));
        rv.h = 15'(base ^ ($urandom_range(0, 3) << 10));
      end else begin
        rv.b = 15'($urandom_range(0, 32767));
        rv.d = 15'($urandom_range(0, 32767));
        rv.f = 15'($urandom_range(0, 32767));
        rv.h = 15'($urandom_range(0, 32767));
      end
      rv.cx = 15'($urandom_range(0, 32767));
      rv.cy = ($urandom_range(0, 1) == 1) ? (rv.cx ^ 15'($urandom_range(0, 1023)))
                                          : 15'($urandom_range(0, 32767));
      rv.exp_blend = 15'(m_blend(rv.rule, rv.dis, rv.e, rv.a, rv.b, rv.d, rv.f, rv.h));
      rv.exp_diff  = m_diff(rv.cx, rv.cy) != 0;
      base = $urandom_range(0, 1);
      drive(base[0], rv);
      tick();
      check($sformatf("rnd%0d_blend", i), {1'b0, bus.blend_out}, {1'b0, rv.exp_blend});
      check($sformatf("rnd%0d_diff", i), {15'h0, bus.diff_out}, {15'h0, rv.exp_diff});
      check($sformatf("rnd%0d_valid", i), {15'h0, bus.out_valid}, {15'h0, base[0]});
    end

    // Mid-stream reset pulse while in_valid stays high.
    drive(1'b1, mk(6'h27, 0, 15'h0000, 0, 15'h7FFF, 15'h7FFF, 0, 0, 15'h7FFF, 15'h0000, 0, 0));
    tick();
    check("stream_valid", {15'h0, bus.out_valid}, 16'h1);
    check("stream_blend", {1'b0, bus.blend_out}, 16'h5EF7);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", {15'h0, bus.out_valid}, 16'h0);
    check("midrst_blend", {1'b0, bus.blend_out}, 16'h0000);
    check("midrst_diff", {15'h0, bus.diff_out}, 16'h0);
    rst_n = 1'b1;
    tick();
    check("resume_valid", {15'h0, bus.out_valid}, 16'h1);
    check("resume_blend", {1'b0, bus.blend_out}, 16'h5EF7);
    check("resume_diff", {15'h0, bus.diff_out}, 16'h1);

    // Single-cycle in_valid pulse.
    bus.in_valid = 1'b0;
    tick();
    check("pulse_pre", {15'h0, bus.out_valid}, 16'h0);
    bus.in_valid = 1'b1;
    tick();
    check("pulse_hi", {15'h0, bus.out_valid}, 16'h1);
    bus.in_valid = 1'b0;
    tick();
    check("pulse_lo1", {15'h0, bus.out_valid}, 16'h0);
    tick();
    check("pulse_lo2", {15'h0, bus.out_valid}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hq_blend_diff.md
HQ_BLEND_DIFF -- requirements
Module: hq_blend_diff

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 in_valid  in  1  input sample valid.
REQ-005 rule  in  6  blend rule; [1:0] selects the compare pair, [5:2] is the blend code c.
REQ-006 disable_hq2x  in  1  forces the output to pass E through.
REQ-007 e, a, b, d, f, h  in  15 each  pixels, format [4:0]=R, [9:5]=G, [14:10]=B, 5-bit unsigned per channel.
REQ-008 cmp_x, cmp_y  in  15 each  standalone diff-check operands.
REQ-009 out_valid  out  1  registered copy of in_valid.
REQ-010 blend_out  out  15  registered blend result.
REQ-011 diff_out  out  1  registered diff(cmp_x, cmp_y).

Function
REQ-012 diff(p,q) SHALL be combinational, per channel: dr/dg/db = p-q as 6-bit signed (-31..31); t=dr+db; y=t+dg; u=dr-db; v=2*dg-t, all full precision.
REQ-013 diff SHALL be 0 (similar) iff -24<=y<=23 and -4<=u<=3 and -6<=v<=5; otherwise 1.
REQ-014 Internal compare: P = rule[1] ? b : h; Q = rule[0] ? d : f; s = !diff(P,Q).
REQ-015 Modes, per channel, integer sum >>4 (truncate), sum <=9 bits, no overflow:
- M0 = E
- M1 = (12E+4X)/16
- M2 = (8E+4X+4Y)/16
- M3 = (10E+4X+2Y)/16
- M4 = (12E+2X+2Y)/16
- M5 = (4E+6X+6Y)/16
- M6 = (14E+X+Y)/16
REQ-016 Codes c=0..7 SHALL ignore s: 0 M0; 1 M1 X=a; 2 M1 X=d; 3 M1 X=b; 4 M2 X=d,Y=b; 5 M2 X=a,Y=b; 6 M2 X=a,Y=d; 7 M0.
REQ-017 Codes c=8..15 with s=0: 8,9,10 M0; 11,12,13 M1 X=a; 14 M1 X=d; 15 M1 X=b.
REQ-018 Codes c=8..15 with s=1: 8 M2; 9 M5; 10 M6; 11 M2; 12 M4; 13 M5; all with X=d, Y=b; 14 M3 X=b,Y=d; 15 M3 X=d,Y=b.
REQ-019 disable_hq2x=1 SHALL force M0 regardless of rule or s.
REQ-020 Every rising edge with rst_n=1 SHALL register blend_out, diff_out and out_valid from current inputs; latency is exactly 1 cycle.
REQ-021 Registers SHALL update every cycle; out_valid only qualifies the result.
REQ-022 All 64 rule values SHALL give defined results; no X propagation.

Reset
REQ-023 rst_n=0 at a rising edge SHALL set blend_out=0x0000, diff_out=0, out_valid=0, overriding any in_valid, including mid-stream.
REQ-024 The first valid result after release SHALL appear one cycle after the first in_valid sampled with rst_n=1.

Verification
REQ-025 cmp_x=0x0000, cmp_y=0x0004 -> diff_out=0 (u=-4 boundary); cmp_y=0x0005 -> diff_out=1.
REQ-026 rule=0x04, E=0x001F, A=0x0000, disable_hq2x=0 -> blend_out=0x0017 one cycle later; disable_hq2x=1 -> 0x001F.
REQ-027 rule=0x27 (c=9, compare B,D), E=0x0000, B=D=0x7FFF -> blend_out=0x5EF7; B=0x7FFF, D=0x0000 -> 0x0000.
REQ-028 rule=0x2B (c=10), B=D=0x7FFF, E=0x0000 -> blend_out=0x0C63 (per channel 62/16=3).
REQ-029 in_valid=1 streamed, rst_n=0 for one cycle -> next cycle out_valid=0, blend_out=0x0000; results resume one cycle after release.
REQ-030 A single-cycle in_valid pulse -> out_valid high for exactly one cycle, one cycle later.
